// File: rtl/stack_return_sequencer.sv
// ---------------------------------------------------------------------------
// stack_return_sequencer
//
// Sequential RET / RET cc / RETI engine for the CPU control unit. Pops the
// return address from the stack (low byte first, then the high byte), holds
// the popped bytes internally, loads PC, and then hands the next opcode
// fetch back to the decoder. It keeps its own M-cycle state and T-step
// counter.
//
// Ports:
//   i_Clk          system clock
//   i_Reset        synchronous, active-high reset
//   i_Start        one-clock request from the decoder to begin a return
//   i_Always       unconditional return (RET/RETI), sampled with i_Start
//   i_RETI         RETI variant, sampled with i_Start
//   i_Cond_Sel     one-hot (or multi-hot) condition select, sampled with i_Start
//   i_Flags        condition flags, sampled with i_Start
//   i_Stall        memory wait state: freezes sequencing
//   i_Data         memory read data
//   o_Busy         sequence in progress
//   o_Address_Out  drive SP onto the address bus
//   o_Bus_In       memory read enable
//   o_SP_Inc       one-clock SP increment strobe
//   o_PC_Load      one-clock PC write strobe
//   o_PC_Value     {hi, lo} popped return address
//   o_EI           one-clock interrupt-enable strobe (RETI only)
//   o_IR_Fetch     one-clock handoff to the decoder for the next fetch
//
// ADDR_WIDTH is expected to be exactly 2*DATA_WIDTH.
// ---------------------------------------------------------------------------
module stack_return_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int COND_WIDTH   = 4,
    parameter int MCYCLE_STEPS = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic                  i_Always,
    input  logic                  i_RETI,
    input  logic [COND_WIDTH-1:0] i_Cond_Sel,
    input  logic [COND_WIDTH-1:0] i_Flags,
    input  logic                  i_Stall,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_Busy,
    output logic                  o_Address_Out,
    output logic                  o_Bus_In,
    output logic                  o_SP_Inc,
    output logic                  o_PC_Load,
    output logic [ADDR_WIDTH-1:0] o_PC_Value,
    output logic                  o_EI,
    output logic                  o_IR_Fetch
);

    localparam int STEP_W = (MCYCLE_STEPS > 1) ? $clog2(MCYCLE_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MCYCLE_STEPS - 1);
    localparam logic [STEP_W-1:0] CAP_STEP  = STEP_W'(MCYCLE_STEPS - 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COND    = 3'd1,
        POP_LO  = 3'd2,
        POP_HI  = 3'd3,
        LOAD_PC = 3'd4
    } state_t;

    state_t                  state_reg;
    logic [STEP_W-1:0]       step_reg;
    logic                    always_reg;
    logic                    reti_reg;
    logic [COND_WIDTH-1:0]   cond_sel_reg;
    logic [COND_WIDTH-1:0]   flags_reg;
    logic [DATA_WIDTH-1:0]   lo_reg;
    logic [DATA_WIDTH-1:0]   hi_reg;

    // Per-condition hit bits; a multi-hot select ORs the selected flags.
    logic [COND_WIDTH-1:0]   cond_hit;
    genvar gi;
    generate
        for (gi = 0; gi < COND_WIDTH; gi++) begin : g_cond_hit
            assign cond_hit[gi] = cond_sel_reg[gi] & flags_reg[gi];
        end
    endgenerate

    logic taken;
    logic last_step;
    logic is_pop;

    assign taken     = always_reg | (|cond_hit);
    assign last_step = (step_reg == LAST_STEP);
    assign is_pop    = (state_reg == POP_LO) || (state_reg == POP_HI);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg    <= IDLE;
            step_reg     <= '0;
            always_reg   <= 1'b0;
            reti_reg     <= 1'b0;
            cond_sel_reg <= '0;
            flags_reg    <= '0;
            lo_reg       <= '0;
            hi_reg       <= '0;
        end else if (!i_Stall) begin
            // A stall freezes state, step and capture; nothing advances.
            case (state_reg)
                IDLE: begin
                    step_reg <= '0;
                    if (i_Start) begin
                        always_reg   <= i_Always;
                        reti_reg     <= i_RETI;
                        cond_sel_reg <= i_Cond_Sel;
                        flags_reg    <= i_Flags;
                        state_reg    <= i_Always ? POP_LO : COND;
                    end
                end
                default: begin
                    if (state_reg == POP_LO && step_reg == CAP_STEP) begin
                        lo_reg <= i_Data;
                    end
                    if (state_reg == POP_HI && step_reg == CAP_STEP) begin
                        hi_reg <= i_Data;
                    end
                    if (last_step) begin
                        step_reg <= '0;
                        case (state_reg)
                            COND:    state_reg <= taken ? POP_LO : IDLE;
                            POP_LO:  state_reg <= POP_HI;
                            POP_HI:  state_reg <= LOAD_PC;
                            default: state_reg <= IDLE;
                        endcase
                    end else begin
                        step_reg <= step_reg + STEP_W'(1);
                    end
                end
            endcase
        end
    end

    // Outputs decode directly from the state/step registers. The one-clock
    // strobes are masked by i_Stall so each fires exactly once, on the first
    // unstalled clock of the final step.
    always_comb begin
        o_Busy        = (state_reg != IDLE);
        o_Address_Out = is_pop;
        o_Bus_In      = is_pop && (step_reg >= STEP_W'(1)) && (step_reg <= CAP_STEP);
        o_SP_Inc      = is_pop && last_step && !i_Stall;
        o_PC_Load     = (state_reg == LOAD_PC) && last_step && !i_Stall;
        o_EI          = (state_reg == LOAD_PC) && last_step && !i_Stall && reti_reg;
        o_IR_Fetch    = last_step && !i_Stall &&
                        ((state_reg == LOAD_PC) || ((state_reg == COND) && !taken));
    end

    assign o_PC_Value = {hi_reg, lo_reg};

endmodule

// File: tb/tb_stack_return_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_return_sequencer
//
// Self-checking bench for stack_return_sequencer. Each return is described
// as a flat list of expected per-step output vectors (one entry per
// unstalled clock), built from the sequence rules: optional condition
// M-cycle, two pop M-cycles, one PC-load M-cycle. A stalled clock repeats
// the current entry with the strobes cleared.
// ---------------------------------------------------------------------------
module tb_stack_return_sequencer;

    localparam int S = 4;

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Start;
    logic        i_Always;
    logic        i_RETI;
    logic [3:0]  i_Cond_Sel;
    logic [3:0]  i_Flags;
    logic        i_Stall;
    logic [7:0]  i_Data;
    logic        o_Busy;
    logic        o_Address_Out;
    logic        o_Bus_In;
    logic        o_SP_Inc;
    logic        o_PC_Load;
    logic [15:0] o_PC_Value;
    logic        o_EI;
    logic        o_IR_Fetch;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] pc_model = 16'h0000;

    stack_return_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16), .COND_WIDTH(4), .MCYCLE_STEPS(S)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start),
        .i_Always(i_Always), .i_RETI(i_RETI), .i_Cond_Sel(i_Cond_Sel),
        .i_Flags(i_Flags), .i_Stall(i_Stall), .i_Data(i_Data),
        .o_Busy(o_Busy), .o_Address_Out(o_Address_Out), .o_Bus_In(o_Bus_In),
        .o_SP_Inc(o_SP_Inc), .o_PC_Load(o_PC_Load), .o_PC_Value(o_PC_Value),
        .o_EI(o_EI), .o_IR_Fetch(o_IR_Fetch)
    );

    always #5 i_Clk = ~i_Clk;

    // {busy, address_out, bus_in, sp_inc, pc_load, ei, ir_fetch}
    function automatic logic [6:0] outs();
        return {o_Busy, o_Address_Out, o_Bus_In, o_SP_Inc, o_PC_Load, o_EI, o_IR_Fetch};
    endfunction

    task automatic test_reset();
        i_Reset = 1'b1; i_Start = 1'b0; i_Always = 1'b0; i_RETI = 1'b0;
        i_Cond_Sel = 4'h0; i_Flags = 4'h0; i_Stall = 1'b0; i_Data = 8'h00;
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
        vectors++;
        if (outs() !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), 7'b0);
        end
        vectors++;
        if (o_PC_Value !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_pc_value: got %h expected %h", o_PC_Value, 16'h0000);
        end
        i_Reset = 1'b0;
        pc_model = 16'h0000;
        $display("txn reset: outputs=%b pc=%h", outs(), o_PC_Value);
    endtask

    // One complete return transaction. stall_at is the index of the
    // unstalled step at which stall_len stalled clocks are inserted (-1: none).
    task automatic run_txn(input string name, input bit alw, input bit reti,
                           input logic [3:0] sel, input logic [3:0] flags,
                           input logic [7:0] lo, input logic [7:0] hi,
                           input int stall_at, input int stall_len);
        logic [6:0] exp_q[$];
        int         cap_q[$];
        bit         taken;
        int         n_mc;
        int         exp_exit;
        int         exit_cyc;
        int         idx;
        int         cyc;
        int         left;
        bit         stall;
        logic [6:0] exp_v;
        logic [6:0] obs;

        taken = alw | (|(sel & flags));
        if (!alw) begin
            for (int k = 0; k < S; k++) begin
                exp_q.push_back({1'b1, 5'b0, (k == S-1) && !taken});
                cap_q.push_back(0);
            end
        end
        if (taken) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < S; k++) begin
                    exp_q.push_back({1'b1, 1'b1, (k >= 1 && k <= S-2), (k == S-1), 3'b000});
                    cap_q.push_back((k == S-2) ? m + 1 : 0);
                end
            end
            for (int k = 0; k < S; k++) begin
                exp_q.push_back({4'b1000, (k == S-1), (k == S-1) && reti, (k == S-1)});
                cap_q.push_back(0);
            end
        end
        n_mc     = (alw ? 0 : 1) + (taken ? 3 : 0);
        exp_exit = n_mc * S + ((stall_at >= 0 && stall_at < exp_q.size()) ? stall_len : 0);

        @(negedge i_Clk);
        i_Start = 1'b1; i_Always = alw; i_RETI = reti;
        i_Cond_Sel = sel; i_Flags = flags; i_Stall = 1'b0;
        i_Data = 8'($urandom);
        @(posedge i_Clk);

        idx = 0; cyc = 0; left = stall_len; exit_cyc = -1;
        while (idx < exp_q.size()) begin
            @(negedge i_Clk);
            cyc++;
            stall = (idx == stall_at) && (left > 0);
            if (stall) left--;
            i_Stall = stall;
            // Starts and mode changes while busy must be ignored.
            i_Start = 1'($urandom_range(0, 1));
            i_Always = 1'($urandom); i_RETI = 1'($urandom);
            i_Cond_Sel = 4'($urandom); i_Flags = 4'($urandom);
            if (cap_q[idx] != 0 && !stall) i_Data = (cap_q[idx] == 1) ? lo : hi;
            else i_Data = 8'($urandom);
            #1;
            exp_v = exp_q[idx];
            if (stall) exp_v = exp_v & 7'b1110000;
            obs = outs();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL %s outputs cycle %0d: got %b expected %b", name, cyc, obs, exp_v);
            end
            if (exp_v[2]) begin
                vectors++;
                if (o_PC_Value !== {hi, lo}) begin
                    miscompares++;
                    $display("FAIL %s pc_value_at_load: got %h expected %h", name, o_PC_Value, {hi, lo});
                end
            end
            if (obs[0] === 1'b1 && exit_cyc < 0) exit_cyc = cyc;
            @(posedge i_Clk);
            if (!stall) idx++;
        end

        if (taken) pc_model = {hi, lo};
        @(negedge i_Clk);
        i_Start = 1'b0; i_Stall = 1'b0;
        #1;
        vectors++;
        if (outs() !== 7'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: got %b expected %b", name, outs(), 7'b0);
        end
        vectors++;
        if (o_PC_Value !== pc_model) begin
            miscompares++;
            $display("FAIL %s pc_value_idle: got %h expected %h", name, o_PC_Value, pc_model);
        end
        vectors++;
        if (exit_cyc !== exp_exit) begin
            miscompares++;
            $display("FAIL %s exit_latency: got %0d expected %0d", name, exit_cyc, exp_exit);
        end
        $display("txn %s: always=%0b reti=%0b sel=%b flags=%b taken=%0b stall_at=%0d len=%0d exit=%0d pc=%h",
                 name, alw, reti, sel, flags, taken, stall_at, stall_len, exit_cyc, o_PC_Value);
    endtask

    task automatic test_ret();
        run_txn("ret", 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h34, 8'h12, -1, 0);
    endtask

    task automatic test_reti();
        run_txn("reti", 1'b1, 1'b1, 4'b0000, 4'b0000, 8'h34, 8'h12, -1, 0);
    endtask

    task automatic test_cond();
        run_txn("retcc_not_taken", 1'b0, 1'b0, 4'b0001, 4'b0000, 8'hAA, 8'hBB, -1, 0);
        run_txn("retcc_taken", 1'b0, 1'b0, 4'b0100, 4'b0100, 8'h78, 8'h56, -1, 0);
        run_txn("retcc_multihot", 1'b0, 1'b0, 4'b1010, 4'b1000, 8'h9A, 8'hBC, -1, 0);
        run_txn("retcc_zero_sel", 1'b0, 1'b0, 4'b0000, 4'b1111, 8'h11, 8'h22, -1, 0);
    endtask

    task automatic test_stall();
        // Step index 6 is POP_HI step 2 (the high-byte capture step).
        run_txn("stall_pop_hi", 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h34, 8'h12, 6, 3);
        run_txn("stall_sp_inc", 1'b1, 1'b1, 4'b0000, 4'b0000, 8'hC3, 8'h5E, 3, 2);
        run_txn("stall_cond_exit", 1'b0, 1'b0, 4'b0010, 4'b0000, 8'h00, 8'h00, 3, 2);
    endtask

    task automatic test_reset_mid();
        @(negedge i_Clk);
        i_Start = 1'b1; i_Always = 1'b1; i_RETI = 1'b1;
        i_Cond_Sel = 4'h0; i_Flags = 4'h0; i_Stall = 1'b0;
        @(posedge i_Clk);
        // Cycles 1..5 cover POP_LO and POP_HI step 0.
        for (int c = 0; c < 5; c++) begin
            @(negedge i_Clk);
            i_Start = 1'b0;
            i_Data = (c == 2) ? 8'hEF : 8'($urandom);
            @(posedge i_Clk);
        end
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
        vectors++;
        if (outs() !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_mid outputs: got %b expected %b", outs(), 7'b0);
        end
        vectors++;
        if (o_PC_Value !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid pc_value: got %h expected %h", o_PC_Value, 16'h0000);
        end
        i_Reset = 1'b0;
        pc_model = 16'h0000;
        $display("txn reset_mid: outputs=%b pc=%h", outs(), o_PC_Value);
        run_txn("after_reset", 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h0D, 8'hF0, -1, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            bit alw;
            bit reti;
            logic [3:0] sel;
            logic [3:0] flg;
            int sa;
            int sl;
            alw  = 1'($urandom);
            reti = alw & 1'($urandom);
            sel  = 4'($urandom);
            flg  = 4'($urandom);
            sa   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 11));
            sl   = int'($urandom_range(1, 3));
            run_txn($sformatf("rand%0d", t), alw, reti, sel, flg,
                    8'($urandom), 8'($urandom), sa, sl);
        end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_a", 1'b1, 1'b0, 4'b0000, 4'b0000, 8'h01, 8'h80, -1, 0);
        run_txn("b2b_b", 1'b0, 1'b0, 4'b1000, 4'b0111, 8'h02, 8'h40, -1, 0);
        run_txn("b2b_c", 1'b1, 1'b1, 4'b0000, 4'b0000, 8'hFF, 8'hFF, -1, 0);
    endtask

    initial begin
        test_reset();
        test_ret();
        test_reti();
        test_cond();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
